sargantana_icache_nb_ctrl: RTL and testbench
============================================

SARGANTANA_ICACHE_NB_CTRL -- requirements
Module: sargantana_icache_nb_ctrl

Interface
REQ-001 SHALL have parameter ICACHE_N_WAY, default 4, the number of ways reported in cline_hit_i.
REQ-002 SHALL have parameter FILL_DEPTH, default 4, the maximum number of outstanding IFILL requests (range 2..8).
REQ-003 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- cache_enable_i  in  1  CSR cache enable.
- flush_i  in  1  flush request.
- ireq_valid_i  in  1  core fetch request.
- ireq_kill_i  in  1  kill the current request.
- mmu_ex_valid_i  in  1  translation exception.
- mmu_miss_i  in  1  TLB miss.
- mmu_ptw_valid_i  in  1  PTW response valid.
- cline_hit_i  in  ICACHE_N_WAY  per-way hit.
- ifill_req_ready_i  in  1  upper level accepts the request.
- ifill_resp_valid_i  in  1  last beat of a fill response, returned in issue order.
- ifill_req_valid_o  out  1  IFILL request valid.
- ifill_req_pf_o  out  1  request is a next-line prefetch.
- iresp_ready_o  out  1  controller accepts a new request.
- iresp_valid_o  out  1  response valid.
- cmp_enable_o  out  1  tag compare enable.
- cache_rd_ena_o  out  1  replay read enable.
- cache_wr_ena_o  out  1  line write enable.
- replay_valid_o  out  1  replay in progress.
- flush_en_o  out  1  flush forwarded.
- miss_o  out  1  PMU demand-miss cycle.
- miss_kill_o  out  1  PMU dropped-fill pulse.
- fill_cnt_o  out  $clog2(FILL_DEPTH+1)  outstanding fill count.

Function
REQ-004 SHALL implement the states IDLE, READ, MISS_REQ, MISS_WAIT, TLB_MISS, KILL_TLB and REPLAY; IDLE SHALL go to READ after one cycle.
REQ-005 SHALL keep an in-order tag FIFO of FILL_DEPTH entries, each tagged DEMAND, PREFETCH or ORPHAN; an accepted request (ifill_req_valid_o && ifill_req_ready_i) SHALL push one entry, and each ifill_resp_valid_i SHALL pop the head entry.
REQ-006 In READ: hit or exception with no mmu_miss_i, a valid request and no kill or flush SHALL give iresp_valid_o=1 in the same cycle.
REQ-007 In READ: no hit, no exception, no TLB miss and no kill or flush SHALL go to MISS_REQ; mmu_miss_i SHALL go to TLB_MISS.
REQ-008 iresp_ready_o SHALL be 1 in READ except on a miss, a TLB miss, or a full FIFO.
REQ-009 MISS_REQ SHALL hold ifill_req_valid_o=1 and ifill_req_pf_o=0 until ready; it SHALL not assert while the FIFO is full, and SHALL then go to MISS_WAIT.
REQ-010 MISS_WAIT SHALL assert miss_o=1 and SHALL do the following on the head pop:
- PREFETCH head: cache_wr_ena_o=1, stay in MISS_WAIT.
- ORPHAN head: cache_wr_ena_o=0 and miss_kill_o=1.
- DEMAND head: cache_wr_ena_o=1, go to REPLAY.
REQ-011 Kill or flush in MISS_REQ or MISS_WAIT SHALL retag every DEMAND entry as ORPHAN and go to READ the next cycle without waiting for the response; a same-cycle DEMAND pop SHALL be treated as ORPHAN.
REQ-012 ORPHAN and PREFETCH pops SHALL also be handled in READ and TLB_MISS without any state change.
REQ-013 REPLAY SHALL drive cache_rd_ena_o=1 and replay_valid_o=1 when there is no kill or exception, and SHALL then go to READ.
REQ-014 TLB_MISS SHALL go to:
- KILL_TLB on kill with no PTW response.
- READ on an exception or kill; iresp_valid_o=mmu_ex_valid_i.
- REPLAY on mmu_ptw_valid_i.
REQ-015 KILL_TLB SHALL wait for mmu_ptw_valid_i and then go to READ.
REQ-016 A push and a pop in the same cycle SHALL leave fill_cnt_o unchanged.
REQ-017 A pop while the FIFO is empty SHALL be ignored.
REQ-018 flush_en_o SHALL be flush_i in every state except IDLE and KILL_TLB.

Reset
REQ-019 rst_i SHALL force IDLE, empty the FIFO and drive every output to 0, including mid-miss; in-flight responses after reset SHALL be ignored because the FIFO is empty.

Configuration
REQ-020 With ICACHE_PREFETCH_EN defined, the cycle after REPLAY SHALL issue one next-line request with ifill_req_pf_o=1, tagged PREFETCH, if the FIFO is not full; it SHALL be dropped if the FIFO is full or a kill occurs.
REQ-021 Without ICACHE_PREFETCH_EN, ifill_req_pf_o SHALL be tied to 0 and no PREFETCH entry SHALL ever be pushed.

Verification
REQ-022 Hit: ireq_valid_i=1, cline_hit_i=4'b0100 -> iresp_valid_o=1 the same cycle, fill_cnt_o=0.
REQ-023 Miss: ireq_valid_i=1, cline_hit_i=0, ready=1 -> fill_cnt_o=1; a response 5 cycles later -> cache_wr_ena_o=1, then REPLAY with cache_rd_ena_o=1, then READ.
REQ-024 Kill under miss: kill in MISS_WAIT -> READ next cycle, iresp_ready_o=1; the later response -> miss_kill_o=1, cache_wr_ena_o=0, fill_cnt_o 1->0.
REQ-025 Full FIFO: FILL_DEPTH=2, two orphaned misses plus a third miss -> ifill_req_valid_o=0 and iresp_ready_o=0 until a pop.
REQ-026 TLB: mmu_miss_i=1 then kill -> KILL_TLB; mmu_ptw_valid_i -> READ.
REQ-027 Prefetch (macro on): miss, then replay -> ifill_req_pf_o=1 one cycle after REPLAY; its response -> cache_wr_ena_o=1 with state unchanged.
REQ-028 Reset mid-miss: rst_i asserted in MISS_WAIT -> all outputs 0 and fill_cnt_o=0; a stale response -> no write.

Source files
------------

// File: rtl/sargantana_icache_nb_ctrl.sv
// ============================================================================
// sargantana_icache_nb_ctrl
//
// Non-blocking instruction-cache controller. A lookup that misses issues an
// IFILL request to the upper level and waits for the line. Several fills may
// be outstanding at once. Each accepted request leaves a tag in an in-order
// FIFO. The tag says what to do when the matching response returns:
//   DEMAND   - line the core is waiting for: write it, then replay the read
//   PREFETCH - next-line prefetch: write it, no state change
//   ORPHAN   - demand fill abandoned by a kill/flush: drop it, pulse miss_kill
//
// Optional feature: define ICACHE_PREFETCH_EN to issue one next-line prefetch
// request in the cycle after every completed replay.
//
// Parameters
//   ICACHE_N_WAY  number of ways in cline_hit_i
//   FILL_DEPTH    maximum outstanding IFILL requests (2..8)
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cache_enable_i        CSR cache enable (a disabled cache never hits)
//   flush_i               flush request
//   ireq_valid_i          core fetch request
//   ireq_kill_i           kill the current request
//   mmu_ex_valid_i        translation exception
//   mmu_miss_i            TLB miss
//   mmu_ptw_valid_i       page-table-walk response valid
//   cline_hit_i           per-way hit vector
//   ifill_req_ready_i     upper level accepts the IFILL request
//   ifill_resp_valid_i    last beat of a fill response (in issue order)
//   ifill_req_valid_o     IFILL request valid
//   ifill_req_pf_o        IFILL request is a next-line prefetch
//   iresp_ready_o         controller accepts a new request
//   iresp_valid_o         response valid
//   cmp_enable_o          tag compare enable
//   cache_rd_ena_o        replay read enable
//   cache_wr_ena_o        line write enable
//   replay_valid_o        replay in progress
//   flush_en_o            flush forwarded to the cache arrays
//   miss_o                PMU demand-miss cycle
//   miss_kill_o           PMU dropped-fill pulse
//   fill_cnt_o            number of outstanding fills
// ============================================================================
module sargantana_icache_nb_ctrl #(
    parameter int ICACHE_N_WAY = 4,
    parameter int FILL_DEPTH   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cache_enable_i,
    input  logic                             flush_i,
    input  logic                             ireq_valid_i,
    input  logic                             ireq_kill_i,
    input  logic                             mmu_ex_valid_i,
    input  logic                             mmu_miss_i,
    input  logic                             mmu_ptw_valid_i,
    input  logic [ICACHE_N_WAY-1:0]          cline_hit_i,
    input  logic                             ifill_req_ready_i,
    input  logic                             ifill_resp_valid_i,
    output logic                             ifill_req_valid_o,
    output logic                             ifill_req_pf_o,
    output logic                             iresp_ready_o,
    output logic                             iresp_valid_o,
    output logic                             cmp_enable_o,
    output logic                             cache_rd_ena_o,
    output logic                             cache_wr_ena_o,
    output logic                             replay_valid_o,
    output logic                             flush_en_o,
    output logic                             miss_o,
    output logic                             miss_kill_o,
    output logic [$clog2(FILL_DEPTH+1)-1:0]  fill_cnt_o
);

    localparam int CNT_W = $clog2(FILL_DEPTH + 1);
    localparam int PTR_W = $clog2(FILL_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FILL_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FILL_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MISS_REQ,
        MISS_WAIT,
        TLB_MISS,
        KILL_TLB,
        REPLAY
    } state_t;

    typedef enum logic [1:0] {
        TAG_DEMAND,
        TAG_PREFETCH,
        TAG_ORPHAN
    } fill_tag_t;

    state_t           state;
    state_t           next_state;
    fill_tag_t        tags [FILL_DEPTH];
    fill_tag_t        push_tag;
    fill_tag_t        head_tag;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             retag;
    logic             fifo_full;
    logic             kill_or_flush;
    logic             hit;
    logic             pf_pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign kill_or_flush = ireq_kill_i | flush_i;
    assign hit           = cache_enable_i & (|cline_hit_i);
    assign fifo_full     = (count == FULL_CNT);
    // A response that arrives with nothing outstanding (e.g. one issued
    // before a reset) has no tag to match, so it is simply ignored.
    assign pop           = ifill_resp_valid_i & (count != '0);
    // Abandoning a miss orphans every demand fill still in flight.
    assign retag         = kill_or_flush & ((state == MISS_REQ) | (state == MISS_WAIT));
    assign fill_cnt_o    = count;

    // A demand response that arrives in the same cycle as the kill is
    // already orphaned, so its line must not be written.
    always_comb begin
        head_tag = tags[head];
        if (retag && head_tag == TAG_DEMAND) begin
            head_tag = TAG_ORPHAN;
        end
    end

`ifdef ICACHE_PREFETCH_EN
    // Arms the single next-line prefetch for the cycle after a clean replay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pf_pending <= 1'b0;
        end else begin
            pf_pending <= (state == REPLAY) && !ireq_kill_i && !mmu_ex_valid_i;
        end
    end
`else
    assign pf_pending = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Tag FIFO. Pushes are never requested while full, and a simultaneous
    // push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FILL_DEPTH; i++) begin
                tags[i] <= TAG_DEMAND;
            end
        end else begin
            if (retag) begin
                for (int i = 0; i < FILL_DEPTH; i++) begin
                    if (tags[i] == TAG_DEMAND) begin
                        tags[i] <= TAG_ORPHAN;
                    end
                end
            end
            if (push) begin
                tags[tail] <= push_tag;
                tail       <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        next_state        = state;
        ifill_req_valid_o = 1'b0;
        ifill_req_pf_o    = 1'b0;
        iresp_ready_o     = 1'b0;
        iresp_valid_o     = 1'b0;
        cmp_enable_o      = 1'b0;
        cache_rd_ena_o    = 1'b0;
        cache_wr_ena_o    = 1'b0;
        replay_valid_o    = 1'b0;
        flush_en_o        = 1'b0;
        miss_o            = 1'b0;
        miss_kill_o       = 1'b0;
        push              = 1'b0;
        push_tag          = TAG_DEMAND;

        // Prefetch and orphan responses are absorbed in whatever state the
        // controller happens to be in; only demand responses steer the FSM.
        if (state != IDLE) begin
            flush_en_o = flush_i && (state != KILL_TLB);
            if (pop && head_tag == TAG_PREFETCH) begin
                cache_wr_ena_o = 1'b1;
            end
            if (pop && head_tag == TAG_ORPHAN) begin
                miss_kill_o = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                next_state = READ;
            end

            READ: begin
                cmp_enable_o = 1'b1;
                if (ireq_valid_i && !kill_or_flush) begin
                    if (mmu_miss_i) begin
                        next_state = TLB_MISS;
                    end else if (hit || mmu_ex_valid_i) begin
                        iresp_valid_o = 1'b1;
                    end else begin
                        next_state = MISS_REQ;
                    end
                end
                iresp_ready_o = (next_state == READ) && !fifo_full;
                // One-shot prefetch: if the upper level is not ready this
                // cycle the prefetch is simply dropped.
                if (pf_pending && !fifo_full && !kill_or_flush) begin
                    ifill_req_valid_o = 1'b1;
                    ifill_req_pf_o    = 1'b1;
                    push              = ifill_req_ready_i;
                    push_tag          = TAG_PREFETCH;
                end
            end

            MISS_REQ: begin
                if (kill_or_flush) begin
                    next_state = READ;
                end else if (!fifo_full) begin
                    ifill_req_valid_o = 1'b1;
                    if (ifill_req_ready_i) begin
                        push       = 1'b1;
                        next_state = MISS_WAIT;
                    end
                end
            end

            MISS_WAIT: begin
                miss_o = 1'b1;
                if (kill_or_flush) begin
                    next_state = READ;
                end else if (pop && head_tag == TAG_DEMAND) begin
                    cache_wr_ena_o = 1'b1;
                    next_state     = REPLAY;
                end
            end

            TLB_MISS: begin
                if (ireq_kill_i && !mmu_ptw_valid_i) begin
                    next_state = KILL_TLB;
                end else if (mmu_ex_valid_i || ireq_kill_i) begin
                    iresp_valid_o = mmu_ex_valid_i;
                    next_state    = READ;
                end else if (mmu_ptw_valid_i) begin
                    next_state = REPLAY;
                end
            end

            // The walk is already in flight; its response must be consumed
            // before a new translation can start.
            KILL_TLB: begin
                if (mmu_ptw_valid_i) begin
                    next_state = READ;
                end
            end

            REPLAY: begin
                if (!ireq_kill_i && !mmu_ex_valid_i) begin
                    cache_rd_ena_o = 1'b1;
                    replay_valid_o = 1'b1;
                end
                next_state = READ;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sargantana_icache_nb_ctrl.sv
// ============================================================================
// tb_sargantana_icache_nb_ctrl
//
// Self-checking bench for sargantana_icache_nb_ctrl (FILL_DEPTH = 2 so the
// full-FIFO behaviour is easy to reach). Inputs are driven on the falling
// edge and every output is compared one time unit later against a
// behavioural model that tracks the controller phase as a name and the
// outstanding fills as a queue of tag characters ('D', 'P', 'O').
// Directed scenarios come first, followed by a randomized run.
// Honours ICACHE_PREFETCH_EN in the same way as the design.
// ============================================================================
`timescale 1ns/1ps
module tb_sargantana_icache_nb_ctrl;

    localparam int N_WAY = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ICACHE_PREFETCH_EN
    localparam bit PF_ON = 1'b1;
`else
    localparam bit PF_ON = 1'b0;
`endif

    logic             clk_i;
    logic             rst_i;
    logic             cache_enable_i;
    logic             flush_i;
    logic             ireq_valid_i;
    logic             ireq_kill_i;
    logic             mmu_ex_valid_i;
    logic             mmu_miss_i;
    logic             mmu_ptw_valid_i;
    logic [N_WAY-1:0] cline_hit_i;
    logic             ifill_req_ready_i;
    logic             ifill_resp_valid_i;
    logic             ifill_req_valid_o;
    logic             ifill_req_pf_o;
    logic             iresp_ready_o;
    logic             iresp_valid_o;
    logic             cmp_enable_o;
    logic             cache_rd_ena_o;
    logic             cache_wr_ena_o;
    logic             replay_valid_o;
    logic             flush_en_o;
    logic             miss_o;
    logic             miss_kill_o;
    logic [CW-1:0]    fill_cnt_o;

    sargantana_icache_nb_ctrl #(
        .ICACHE_N_WAY(N_WAY),
        .FILL_DEPTH  (DEPTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cache_enable_i    (cache_enable_i),
        .flush_i           (flush_i),
        .ireq_valid_i      (ireq_valid_i),
        .ireq_kill_i       (ireq_kill_i),
        .mmu_ex_valid_i    (mmu_ex_valid_i),
        .mmu_miss_i        (mmu_miss_i),
        .mmu_ptw_valid_i   (mmu_ptw_valid_i),
        .cline_hit_i       (cline_hit_i),
        .ifill_req_ready_i (ifill_req_ready_i),
        .ifill_resp_valid_i(ifill_resp_valid_i),
        .ifill_req_valid_o (ifill_req_valid_o),
        .ifill_req_pf_o    (ifill_req_pf_o),
        .iresp_ready_o     (iresp_ready_o),
        .iresp_valid_o     (iresp_valid_o),
        .cmp_enable_o      (cmp_enable_o),
        .cache_rd_ena_o    (cache_rd_ena_o),
        .cache_wr_ena_o    (cache_wr_ena_o),
        .replay_valid_o    (replay_valid_o),
        .flush_en_o        (flush_en_o),
        .miss_o            (miss_o),
        .miss_kill_o       (miss_kill_o),
        .fill_cnt_o        (fill_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             rst;
        logic             en;
        logic             flush;
        logic             valid;
        logic             kill;
        logic             ex;
        logic             mmiss;
        logic             ptw;
        logic             ready;
        logic             resp;
        logic [N_WAY-1:0] hit;
    } stim_t;

    int vectors;
    int miscompares;
    int cycle_no;

    string m_phase;
    string n_phase;
    byte   tag_q[$];
    bit    pf_armed;
    bit    n_pf_armed;
    bit    do_pop;
    bit    do_retag;
    byte   push_tag;

    logic          e_ifill_valid, e_pf, e_ready, e_resp_valid, e_cmp, e_rd;
    logic          e_wr, e_replay, e_flush_en, e_miss, e_miss_kill;
    logic [CW-1:0] e_fill_cnt;

    function automatic stim_t quiet();
        stim_t s;
        s    = '0;
        s.en = 1'b1;
        return s;
    endfunction

    task automatic check_bit(input string name, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s cycle %0d: observed %b, expected %b", name, cycle_no, obs, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s cycle %0d: observed %0d, expected %0d", name, cycle_no, obs, exp);
        end
    endtask

    // Expected outputs for the current cycle, plus the pending model update.
    task automatic model_eval(input stim_t s);
        bit  kf;
        bit  hit_any;
        bit  full;
        byte head;
        e_ifill_valid = 0; e_pf = 0; e_ready = 0; e_resp_valid = 0; e_cmp = 0;
        e_rd = 0; e_wr = 0; e_replay = 0; e_flush_en = 0; e_miss = 0; e_miss_kill = 0;
        e_fill_cnt = '0;
        n_phase    = m_phase;
        n_pf_armed = 1'b0;
        do_pop     = 1'b0;
        do_retag   = 1'b0;
        push_tag   = 0;
        if (s.rst) begin
            n_phase = "IDLE";
            return;
        end
        kf         = s.kill || s.flush;
        hit_any    = s.en && (s.hit != '0);
        full       = (tag_q.size() == DEPTH);
        e_fill_cnt = CW'(tag_q.size());
        do_pop     = s.resp && (tag_q.size() > 0);
        do_retag   = kf && (m_phase == "MISS_REQ" || m_phase == "MISS_WAIT");
        head       = do_pop ? tag_q[0] : "-";
        if (do_retag && head == "D") head = "O";

        if (m_phase != "IDLE") begin
            e_flush_en = s.flush && (m_phase != "KILL_TLB");
            if (head == "P") e_wr = 1;
            if (head == "O") e_miss_kill = 1;
        end

        if (m_phase == "IDLE") begin
            n_phase = "READ";
        end else if (m_phase == "READ") begin
            e_cmp = 1;
            if (s.valid && !kf) begin
                if (s.mmiss) n_phase = "TLB_MISS";
                else if (hit_any || s.ex) e_resp_valid = 1;
                else n_phase = "MISS_REQ";
            end
            e_ready = (n_phase == "READ") && !full;
            if (pf_armed && !full && !kf) begin
                e_ifill_valid = 1;
                e_pf          = 1;
                if (s.ready) push_tag = "P";
            end
        end else if (m_phase == "MISS_REQ") begin
            if (kf) begin
                n_phase = "READ";
            end else if (!full) begin
                e_ifill_valid = 1;
                if (s.ready) begin
                    push_tag = "D";
                    n_phase  = "MISS_WAIT";
                end
            end
        end else if (m_phase == "MISS_WAIT") begin
            e_miss = 1;
            if (kf) begin
                n_phase = "READ";
            end else if (head == "D") begin
                e_wr    = 1;
                n_phase = "REPLAY";
            end
        end else if (m_phase == "TLB_MISS") begin
            if (s.kill && !s.ptw) begin
                n_phase = "KILL_TLB";
            end else if (s.ex || s.kill) begin
                e_resp_valid = s.ex;
                n_phase      = "READ";
            end else if (s.ptw) begin
                n_phase = "REPLAY";
            end
        end else if (m_phase == "KILL_TLB") begin
            if (s.ptw) n_phase = "READ";
        end else if (m_phase == "REPLAY") begin
            if (!s.kill && !s.ex) begin
                e_rd       = 1;
                e_replay   = 1;
                n_pf_armed = PF_ON;
            end
            n_phase = "READ";
        end
    endtask

    task automatic model_commit(input stim_t s);
        if (s.rst) begin
            tag_q.delete();
            m_phase  = "IDLE";
            pf_armed = 1'b0;
            return;
        end
        if (do_retag) begin
            foreach (tag_q[i]) if (tag_q[i] == "D") tag_q[i] = "O";
        end
        if (do_pop) void'(tag_q.pop_front());
        if (push_tag != 0) tag_q.push_back(push_tag);
        m_phase  = n_phase;
        pf_armed = n_pf_armed;
    endtask

    task automatic checkOutput(input string step);
        check_bit({step, ".ifill_req_valid"}, ifill_req_valid_o, e_ifill_valid);
        check_bit({step, ".ifill_req_pf"},    ifill_req_pf_o,    e_pf);
        check_bit({step, ".iresp_ready"},     iresp_ready_o,     e_ready);
        check_bit({step, ".iresp_valid"},     iresp_valid_o,     e_resp_valid);
        check_bit({step, ".cmp_enable"},      cmp_enable_o,      e_cmp);
        check_bit({step, ".cache_rd_ena"},    cache_rd_ena_o,    e_rd);
        check_bit({step, ".cache_wr_ena"},    cache_wr_ena_o,    e_wr);
        check_bit({step, ".replay_valid"},    replay_valid_o,    e_replay);
        check_bit({step, ".flush_en"},        flush_en_o,        e_flush_en);
        check_bit({step, ".miss"},            miss_o,            e_miss);
        check_bit({step, ".miss_kill"},       miss_kill_o,       e_miss_kill);
        check_cnt({step, ".fill_cnt"},        fill_cnt_o,        e_fill_cnt);
    endtask

    // Drives one cycle of inputs on the falling edge, then checks the
    // combinational outputs against the model before the next rising edge.
    task automatic applyStimulus(input stim_t s, input string step);
        @(negedge clk_i);
        rst_i              = s.rst;
        cache_enable_i     = s.en;
        flush_i            = s.flush;
        ireq_valid_i       = s.valid;
        ireq_kill_i        = s.kill;
        mmu_ex_valid_i     = s.ex;
        mmu_miss_i         = s.mmiss;
        mmu_ptw_valid_i    = s.ptw;
        cline_hit_i        = s.hit;
        ifill_req_ready_i  = s.ready;
        ifill_resp_valid_i = s.resp;
        #1;
        cycle_no++;
        model_eval(s);
        checkOutput(step);
        model_commit(s);
    endtask

    // READ with a missing request, then MISS_REQ with the request accepted.
    task automatic issue_miss(input string step);
        stim_t s;
        s       = quiet();
        s.valid = 1'b1;
        s.ready = 1'b1;
        applyStimulus(s, {step, "_read"});
        s = quiet();
        s.ready = 1'b1;
        applyStimulus(s, {step, "_req"});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        vectors     = 0;
        miscompares = 0;
        cycle_no    = 0;
        m_phase     = "IDLE";
        pf_armed    = 1'b0;
        rst_i              = 1'b1;
        cache_enable_i     = 1'b1;
        flush_i            = 1'b0;
        ireq_valid_i       = 1'b0;
        ireq_kill_i        = 1'b0;
        mmu_ex_valid_i     = 1'b0;
        mmu_miss_i         = 1'b0;
        mmu_ptw_valid_i    = 1'b0;
        cline_hit_i        = '0;
        ifill_req_ready_i  = 1'b0;
        ifill_resp_valid_i = 1'b0;

        // Reset state
        s = quiet(); s.rst = 1'b1;
        applyStimulus(s, "reset0");
        applyStimulus(s, "reset1");
        check_cnt("reset_fill_cnt", fill_cnt_o, CW'(0));
        s = quiet();
        applyStimulus(s, "idle");

        // Hit answered in the same cycle
        s = quiet(); s.valid = 1'b1; s.hit = 4'b0100;
        applyStimulus(s, "hit");
        check_bit("hit_resp_valid", iresp_valid_o, 1'b1);
        check_cnt("hit_fill_cnt", fill_cnt_o, CW'(0));

        // Demand miss, response five cycles after the request, then replay
        s = quiet(); s.valid = 1'b1; s.ready = 1'b1;
        applyStimulus(s, "miss_read");
        check_bit("miss_ready_low", iresp_ready_o, 1'b0);
        s = quiet(); s.ready = 1'b1;
        applyStimulus(s, "miss_req");
        check_bit("miss_req_valid", ifill_req_valid_o, 1'b1);
        check_bit("miss_req_pf", ifill_req_pf_o, 1'b0);
        s = quiet();
        for (int i = 0; i < 4; i++) applyStimulus(s, "miss_wait");
        check_cnt("miss_fill_cnt", fill_cnt_o, CW'(1));
        check_bit("miss_pmu", miss_o, 1'b1);
        s.resp = 1'b1;
        applyStimulus(s, "miss_resp");
        check_bit("miss_wr", cache_wr_ena_o, 1'b1);
        s = quiet();
        applyStimulus(s, "miss_replay");
        check_bit("miss_replay_rd", cache_rd_ena_o, 1'b1);
        check_bit("miss_replay_valid", replay_valid_o, 1'b1);
        s = quiet(); s.ready = 1'b1;
        applyStimulus(s, "after_replay");
        check_bit("after_replay_pf", ifill_req_pf_o, PF_ON);
        check_bit("after_replay_cmp", cmp_enable_o, 1'b1);
        s = quiet(); s.resp = 1'b1;
        applyStimulus(s, "pf_resp");
        check_bit("pf_resp_wr", cache_wr_ena_o, PF_ON);
        check_bit("pf_resp_ready", iresp_ready_o, 1'b1);
        s = quiet();
        applyStimulus(s, "pf_settle");
        check_cnt("pf_settle_cnt", fill_cnt_o, CW'(0));

        // Kill while waiting: back to READ, late response is dropped
        issue_miss("kmiss");
        s = quiet();
        applyStimulus(s, "kmiss_wait");
        s.kill = 1'b1;
        applyStimulus(s, "kmiss_kill");
        s = quiet();
        applyStimulus(s, "kmiss_back");
        check_bit("kmiss_ready", iresp_ready_o, 1'b1);
        check_cnt("kmiss_cnt_before", fill_cnt_o, CW'(1));
        s.resp = 1'b1;
        applyStimulus(s, "kmiss_resp");
        check_bit("kmiss_miss_kill", miss_kill_o, 1'b1);
        check_bit("kmiss_no_wr", cache_wr_ena_o, 1'b0);
        s = quiet();
        applyStimulus(s, "kmiss_drain");
        check_cnt("kmiss_cnt_after", fill_cnt_o, CW'(0));

        // Full FIFO: two orphaned misses plus a third miss
        for (int k = 0; k < 2; k++) begin
            issue_miss("orph");
            s = quiet(); s.flush = 1'b1;
            applyStimulus(s, "orph_flush");
        end
        s = quiet();
        applyStimulus(s, "full_read");
        check_bit("full_ready_low", iresp_ready_o, 1'b0);
        check_cnt("full_cnt", fill_cnt_o, CW'(2));
        s = quiet(); s.valid = 1'b1;
        applyStimulus(s, "full_third");
        s = quiet(); s.ready = 1'b1;
        applyStimulus(s, "full_req0");
        check_bit("full_req0_valid", ifill_req_valid_o, 1'b0);
        check_bit("full_req0_ready", iresp_ready_o, 1'b0);
        applyStimulus(s, "full_req1");
        check_bit("full_req1_valid", ifill_req_valid_o, 1'b0);
        s.resp = 1'b1;
        applyStimulus(s, "full_pop");
        check_bit("full_pop_kill", miss_kill_o, 1'b1);
        s = quiet(); s.ready = 1'b1;
        applyStimulus(s, "full_push");
        check_bit("full_push_valid", ifill_req_valid_o, 1'b1);
        s = quiet(); s.resp = 1'b1;
        applyStimulus(s, "full_pop_orphan");
        check_bit("full_orphan_kill", miss_kill_o, 1'b1);
        applyStimulus(s, "full_pop_demand");
        check_bit("full_demand_wr", cache_wr_ena_o, 1'b1);
        s = quiet();
        applyStimulus(s, "full_replay");
        check_bit("full_replay_rd", cache_rd_ena_o, 1'b1);
        applyStimulus(s, "full_after");

        // TLB miss killed mid-walk waits for the PTW response
        s = quiet(); s.valid = 1'b1; s.mmiss = 1'b1;
        applyStimulus(s, "tlb_read");
        check_bit("tlb_ready_low", iresp_ready_o, 1'b0);
        s = quiet(); s.kill = 1'b1;
        applyStimulus(s, "tlb_kill");
        s = quiet(); s.flush = 1'b1;
        applyStimulus(s, "killtlb_wait");
        check_bit("killtlb_flush_blocked", flush_en_o, 1'b0);
        s = quiet(); s.ptw = 1'b1;
        applyStimulus(s, "killtlb_ptw");
        s = quiet(); s.flush = 1'b1;
        applyStimulus(s, "killtlb_back");
        check_bit("killtlb_back_cmp", cmp_enable_o, 1'b1);
        check_bit("killtlb_back_flush", flush_en_o, 1'b1);

        // TLB miss resolved by the walk, then with an exception
        s = quiet(); s.valid = 1'b1; s.mmiss = 1'b1;
        applyStimulus(s, "tlbok_read");
        s = quiet(); s.ptw = 1'b1;
        applyStimulus(s, "tlbok_ptw");
        s = quiet();
        applyStimulus(s, "tlbok_replay");
        check_bit("tlbok_replay_rd", cache_rd_ena_o, 1'b1);
        applyStimulus(s, "tlbok_after");
        s = quiet(); s.valid = 1'b1; s.mmiss = 1'b1;
        applyStimulus(s, "tlbex_read");
        s = quiet(); s.ex = 1'b1;
        applyStimulus(s, "tlbex_ex");
        check_bit("tlbex_resp", iresp_valid_o, 1'b1);

        // Reset in the middle of a miss; the stale response is ignored
        issue_miss("rmiss");
        s = quiet();
        applyStimulus(s, "rmiss_wait");
        s = quiet(); s.rst = 1'b1; s.flush = 1'b1;
        applyStimulus(s, "rmiss_reset");
        check_bit("rmiss_reset_miss", miss_o, 1'b0);
        check_cnt("rmiss_reset_cnt", fill_cnt_o, CW'(0));
        s = quiet(); s.resp = 1'b1;
        applyStimulus(s, "rmiss_stale0");
        applyStimulus(s, "rmiss_stale1");
        check_bit("rmiss_stale_wr", cache_wr_ena_o, 1'b0);
        check_cnt("rmiss_stale_cnt", fill_cnt_o, CW'(0));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            s       = quiet();
            s.rst   = ($urandom_range(0, 299) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.kill  = ($urandom_range(0, 11) == 0);
            s.flush = ($urandom_range(0, 19) == 0);
            s.ex    = ($urandom_range(0, 9) == 0);
            s.mmiss = ($urandom_range(0, 7) == 0);
            s.ptw   = ($urandom_range(0, 3) == 0);
            s.ready = ($urandom_range(0, 2) != 0);
            s.resp  = ($urandom_range(0, 3) == 0);
            s.hit   = ($urandom_range(0, 1) != 0) ? N_WAY'(1 << $urandom_range(0, N_WAY - 1)) : '0;
            applyStimulus(s, "rand");
        end
        s = quiet();
        for (int n = 0; n < 4; n++) applyStimulus(s, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
